// File: rtl/qspi_ddr_tx.sv
// qspi_ddr_tx
// Transmit serializer for an N-lane DDR flash/PSRAM bus. Whole words come in
// on a valid/ready stream. Each word leaves MSB first as LANES-bit pairs that
// feed one ODDRX1F per lane. The block also drives chip select, the SCK ODDR
// clock enable and the per-lane tristate controls for the pads.
//
// Ports:
//   clk       system clock (also the ODDRX1F SCLK)
//   rst_n     asynchronous active-low reset
//   in_valid  input word valid
//   in_data   input word, sent MSB first
//   in_last   final word of the transaction (sampled on accept only)
//   in_ready  combinational; a word is accepted when in_valid & in_ready
//   abort     synchronous abort of the current transaction
//   cs_n      chip select, active low (registered)
//   sck_en    bus clock gate for the SCK ODDR D0/D1 (registered)
//   io_t      per-lane tristate, 1 = released (registered)
//   ddr_d0    lane bits for the first half-cycle (registered)
//   ddr_d1    lane bits for the second half-cycle (registered)
//   busy      high whenever the block is not idle (registered)
module qspi_ddr_tx #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              abort,
  output logic              cs_n,
  output logic              sck_en,
  output logic [LANES-1:0]  io_t,
  output logic [LANES-1:0]  ddr_d0,
  output logic [LANES-1:0]  ddr_d1,
  output logic              busy
);

  localparam int BEATS   = DATA_W / (2 * LANES);
  localparam int STEP    = 2 * LANES;
  localparam int CNT_MAX = (BEATS > CS_GAP) ? BEATS : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_DATA,
    S_STALL,
    S_TAIL,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic                r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cs_n;
  logic                r_sck_en;
  logic [LANES-1:0]    r_io_t;
  logic [LANES-1:0]    r_d0;
  logic [LANES-1:0]    r_d1;
  logic                r_busy;

  state_t              w_state_nx;
  logic [DATA_W-1:0]   w_shreg_nx;
  logic                w_last_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [LANES-1:0]    w_d0_nx;
  logic [LANES-1:0]    w_d1_nx;
  logic [DATA_W-1:0]   w_src;
  logic                w_take_beat;
  logic                w_final;
  logic                w_abort_hit;
  logic                w_accept;

  // Final beat of the word currently on the pins.
  assign w_final     = (r_state == S_DATA) && (r_cnt == LAST_BEAT);
  // abort only acts while cs_n is (or is about to be) asserted.
  assign w_abort_hit = abort && ((r_state == S_LEAD) || (r_state == S_DATA) ||
                                 (r_state == S_STALL) || (r_state == S_TAIL));

  assign in_ready = !w_abort_hit &&
                    ((r_state == S_IDLE) || (r_state == S_STALL) || (w_final && !r_last));
  assign w_accept = in_valid && in_ready;

  // Next-state and datapath. A beat is taken either from the shift register
  // or, on a reload from DATA/STALL, directly from in_data so the new word
  // appears on the pins the cycle after it is accepted (no bubble).
  always_comb begin
    w_state_nx  = r_state;
    w_shreg_nx  = r_shreg;
    w_last_nx   = r_last;
    w_cnt_nx    = r_cnt;
    w_d0_nx     = r_d0;
    w_d1_nx     = r_d1;
    w_src       = r_shreg;
    w_take_beat = 1'b0;

    if (w_abort_hit) begin
      w_state_nx = S_GAP;
      w_shreg_nx = '0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_shreg_nx = in_data;
            w_last_nx  = in_last;
            w_state_nx = S_LEAD;
          end
        end
        S_LEAD: begin
          w_take_beat = 1'b1;
          w_cnt_nx    = '0;
          w_state_nx  = S_DATA;
        end
        S_DATA: begin
          if (!w_final) begin
            w_take_beat = 1'b1;
            w_cnt_nx    = r_cnt + CNT_W'(1);
          end else if (w_accept) begin
            w_src       = in_data;
            w_take_beat = 1'b1;
            w_last_nx   = in_last;
            w_cnt_nx    = '0;
          end else if (r_last) begin
            w_state_nx = S_TAIL;
          end else begin
            w_state_nx = S_STALL;
          end
        end
        S_STALL: begin
          if (w_accept) begin
            w_src       = in_data;
            w_take_beat = 1'b1;
            w_last_nx   = in_last;
            w_cnt_nx    = '0;
            w_state_nx  = S_DATA;
          end
        end
        S_TAIL: begin
          w_cnt_nx   = '0;
          w_state_nx = S_GAP;
        end
        S_GAP: begin
          if (r_cnt == GAP_END) begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end

    if (w_take_beat) begin
      w_d0_nx    = w_src[DATA_W-1 -: LANES];
      w_d1_nx    = w_src[DATA_W-1-LANES -: LANES];
      w_shreg_nx = w_src << STEP;
    end
  end

  // Pad controls are registered from the next state so they line up with
  // the data beats on the ODDR inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_cs_n   <= 1'b1;
      r_sck_en <= 1'b0;
      r_io_t   <= '1;
      r_d0     <= '0;
      r_d1     <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_shreg  <= w_shreg_nx;
      r_last   <= w_last_nx;
      r_cnt    <= w_cnt_nx;
      r_d0     <= w_d0_nx;
      r_d1     <= w_d1_nx;
      r_cs_n   <= !((w_state_nx == S_LEAD) || (w_state_nx == S_DATA) ||
                    (w_state_nx == S_STALL) || (w_state_nx == S_TAIL));
      r_io_t   <= ((w_state_nx == S_LEAD) || (w_state_nx == S_DATA) ||
                   (w_state_nx == S_STALL)) ? '0 : '1;
      r_sck_en <= (w_state_nx == S_DATA);
      r_busy   <= (w_state_nx != S_IDLE);
    end
  end

  assign cs_n   = r_cs_n;
  assign sck_en = r_sck_en;
  assign io_t   = r_io_t;
  assign ddr_d0 = r_d0;
  assign ddr_d1 = r_d1;
  assign busy   = r_busy;

endmodule
